// File: rtl/reaction_timer_multi.sv
// reaction_timer_multi: multi-player reaction timer with random stimulus delay, foul/timeout detection and best-time tracking
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   startBtn          start level (edge starts a round from IDLE/DONE/FOUL/TIMEOUT)
//   testmodeBtn       selects fixed TEST_DELAY instead of random delay at round start
//   playerBtn         player button levels
//   stimLed           stimulus lamp, high in GO
//   bcd               current/last reaction time, 4 BCD digits in ticks
//   bestBcd/bestValid best valid time since reset
//   winner/tie        lowest-index pressing player, more than one pressed together
//   foulMask          players that pressed during WAIT
//   state             FSM state code
module reaction_timer_multi #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 1000,
    parameter int PLAYERS    = 2,
    parameter int MIN_DELAY  = 1000,
    parameter int RAND_BITS  = 12,
    parameter int TEST_DELAY = 500
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startBtn,
    input  logic               testmodeBtn,
    input  logic [PLAYERS-1:0] playerBtn,
    output logic               stimLed,
    output logic [15:0]        bcd,
    output logic [15:0]        bestBcd,
    output logic               bestValid,
    output logic [2:0]         winner,
    output logic [PLAYERS-1:0] foulMask,
    output logic               tie,
    output logic [2:0]         state
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE = 3'd0, WAIT = 3'd1, GO = 3'd2, DONE = 3'd3, FOUL = 3'd4, TIMEOUT = 3'd5} state_t;

    state_t             r_state, w_next;
    logic [2:0]         r_start_s;
    logic [1:0]         r_test_s;
    logic [PLAYERS-1:0] r_p1, r_p2, r_p3;
    logic [15:0]        r_lfsr;
    logic [PW-1:0]      r_pre;
    logic [31:0]        r_delay, w_delay;
    logic [15:0]        r_bcd, w_bcd, r_best, w_best, w_bcd_inc;
    logic               r_bv, w_bv, r_tie, w_tie, r_stim;
    logic [2:0]         r_win, w_win, w_low;
    logic [PLAYERS-1:0] r_fm, w_fm, w_pe;
    logic               w_se, w_tick, w_multi;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign w_se      = r_start_s[1] & ~r_start_s[2];
    assign w_pe      = r_p2 & ~r_p3;
    assign w_tick    = r_pre == PW'(DIV - 1);
    assign w_bcd_inc = bcd_inc(r_bcd);
    // more than one bit set: clearing the lowest set bit leaves something
    assign w_multi   = (w_pe & (w_pe - 1'b1)) != '0;

    always_comb begin
        w_low = 3'd0;
        for (int i = PLAYERS - 1; i >= 0; i--)
            if (w_pe[i]) w_low = 3'(i);
    end

    always_comb begin
        w_next  = r_state;
        w_delay = r_delay;
        w_bcd   = r_bcd;
        w_best  = r_best;
        w_bv    = r_bv;
        w_win   = r_win;
        w_fm    = r_fm;
        w_tie   = r_tie;
        if (r_state == DONE && (!r_bv || r_bcd < r_best)) begin
            w_best = r_bcd;
            w_bv   = 1'b1;
        end
        case (r_state)
            WAIT: begin
                if (|w_pe) begin
                    w_next = FOUL;
                    w_fm   = w_pe;
                end else if (w_tick) begin
                    w_delay = r_delay - 32'd1;
                    w_next  = r_delay <= 32'd1 ? GO : WAIT;
                end
            end
            GO: begin
                if (|w_pe) begin
                    w_next = DONE;
                    w_win  = w_low;
                    w_tie  = w_multi;
                end else if (w_tick) begin
                    w_bcd  = w_bcd_inc;
                    w_next = w_bcd_inc == 16'h9999 ? TIMEOUT : GO;
                end
            end
            default: begin
                if (w_se) begin
                    w_next  = WAIT;
                    w_delay = r_test_s[1] ? 32'(TEST_DELAY) : 32'(MIN_DELAY) + 32'(r_lfsr[RAND_BITS-1:0]);
                    w_bcd   = 16'h0000;
                    w_fm    = '0;
                    w_tie   = 1'b0;
                    w_win   = 3'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_start_s <= '0;
            r_test_s  <= '0;
            r_p1      <= '0;
            r_p2      <= '0;
            r_p3      <= '0;
            r_lfsr    <= 16'hACE1;
            r_pre     <= '0;
            r_delay   <= '0;
            r_bcd     <= '0;
            r_best    <= '0;
            r_bv      <= 1'b0;
            r_win     <= '0;
            r_fm      <= '0;
            r_tie     <= 1'b0;
            r_stim    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_start_s <= {r_start_s[1:0], startBtn};
            r_test_s  <= {r_test_s[0], testmodeBtn};
            r_p1      <= playerBtn;
            r_p2      <= r_p1;
            r_p3      <= r_p2;
            r_lfsr    <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            // restart the tick phase on entry to WAIT/GO so the first tick lands DIV cycles later
            r_pre     <= (w_next != r_state && (w_next == WAIT || w_next == GO)) || w_tick ? '0 : r_pre + 1'b1;
            r_delay   <= w_delay;
            r_bcd     <= w_bcd;
            r_best    <= w_best;
            r_bv      <= w_bv;
            r_win     <= w_win;
            r_fm      <= w_fm;
            r_tie     <= w_tie;
            r_stim    <= w_next == GO;
        end
    end

    assign stimLed   = r_stim;
    assign bcd       = r_bcd;
    assign bestBcd   = r_best;
    assign bestValid = r_bv;
    assign winner    = r_win;
    assign foulMask  = r_fm;
    assign tie       = r_tie;
    assign state     = r_state;
endmodule

// File: tb/tb_reaction_timer_multi.sv
// tb_reaction_timer_multi: directed, table-driven bench for reaction_timer_multi
module tb_reaction_timer_multi;
    logic        clk = 1'b0;
    logic        reset, startBtn, testmodeBtn;
    logic [3:0]  playerBtn;
    logic        stimLed, bestValid, tie;
    logic [15:0] bcd, bestBcd;
    logic [2:0]  winner, state;
    logic [3:0]  foulMask;

    logic        f_reset, f_start;
    logic [3:0]  f_player;
    logic        f_stim, f_bv, f_tie;
    logic [15:0] f_bcd, f_best;
    logic [2:0]  f_win, f_state;
    logic [3:0]  f_fm;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reaction_timer_multi #(.CLK_HZ(1000), .TICK_HZ(100), .PLAYERS(4), .MIN_DELAY(20), .RAND_BITS(4), .TEST_DELAY(5)) dut (
        .clk(clk), .reset(reset), .startBtn(startBtn), .testmodeBtn(testmodeBtn), .playerBtn(playerBtn),
        .stimLed(stimLed), .bcd(bcd), .bestBcd(bestBcd), .bestValid(bestValid), .winner(winner),
        .foulMask(foulMask), .tie(tie), .state(state)
    );

    // one tick per clock so the full 9999-tick timeout stays short
    reaction_timer_multi #(.CLK_HZ(100), .TICK_HZ(100), .PLAYERS(4), .MIN_DELAY(20), .RAND_BITS(4), .TEST_DELAY(5)) u_fast (
        .clk(clk), .reset(f_reset), .startBtn(f_start), .testmodeBtn(1'b1), .playerBtn(f_player),
        .stimLed(f_stim), .bcd(f_bcd), .bestBcd(f_best), .bestValid(f_bv), .winner(f_win),
        .foulMask(f_fm), .tie(f_tie), .state(f_state)
    );

    typedef struct {
        logic        foul;
        logic [3:0]  mask;
        int          ticks;
        logic [2:0]  e_state;
        logic [15:0] e_bcd;
        logic [2:0]  e_win;
        logic        e_tie;
        logic [3:0]  e_fm;
        logic [15:0] e_best;
        logic        e_bv;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic enter_wait(input string nm);
        int n;
        n = 0;
        @(negedge clk) startBtn = 1'b1;
        while (state != 3'd1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        startBtn = 1'b0;
        chk({nm, "_wait"}, 32'(state), 32'd1);
    endtask

    // counts cycles from WAIT entry to stimLed, poking start (must be ignored) along the way
    task automatic wait_stim(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 10) startBtn = 1'b1;
            if (n == 13) startBtn = 1'b0;
        end while (!stimLed && n < 200);
        chk({nm, "_stim_delay"}, 32'(n), 32'd50);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string nm;
        logic  seen;
        nm = $sformatf("v%0d", idx);
        enter_wait(nm);
        if (v.foul) begin
            repeat (20) @(negedge clk);
            playerBtn = v.mask;
            seen = 1'b0;
            for (int i = 0; i < 80; i++) begin
                @(negedge clk);
                if (i == 4) playerBtn = 4'd0;
                seen |= stimLed;
            end
            chk({nm, "_stim_never"}, 32'(seen), 32'd0);
        end else begin
            wait_stim(nm);
            for (int i = 0; i < v.ticks * 10; i++) begin
                @(negedge clk);
                if (i == 5) startBtn = 1'b1;
                if (i == 8) startBtn = 1'b0;
            end
            playerBtn = v.mask;
            repeat (4) @(negedge clk);
            playerBtn = 4'd0;
            repeat (4) @(negedge clk);
        end
        chk({nm, "_state"}, 32'(state), 32'(v.e_state));
        chk({nm, "_bcd"}, 32'(bcd), 32'(v.e_bcd));
        chk({nm, "_winner"}, 32'(winner), 32'(v.e_win));
        chk({nm, "_tie"}, 32'(tie), 32'(v.e_tie));
        chk({nm, "_foulmask"}, 32'(foulMask), 32'(v.e_fm));
        chk({nm, "_best"}, 32'(bestBcd), 32'(v.e_best));
        chk({nm, "_bestvalid"}, 32'(bestValid), 32'(v.e_bv));
        chk({nm, "_stim_low"}, 32'(stimLed), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        f_reset = 1'b1;
        startBtn = 1'b0;
        f_start = 1'b0;
        testmodeBtn = 1'b1;
        playerBtn = 4'd0;
        f_player = 4'd0;
        vecs[0] = '{1'b0, 4'b0100, 123, 3'd3, 16'h0123, 3'd2, 1'b0, 4'b0000, 16'h0123, 1'b1};
        vecs[1] = '{1'b0, 4'b0001, 200, 3'd3, 16'h0200, 3'd0, 1'b0, 4'b0000, 16'h0123, 1'b1};
        vecs[2] = '{1'b0, 4'b1000, 45, 3'd3, 16'h0045, 3'd3, 1'b0, 4'b0000, 16'h0045, 1'b1};
        vecs[3] = '{1'b1, 4'b1010, 0, 3'd4, 16'h0000, 3'd0, 1'b0, 4'b1010, 16'h0045, 1'b1};
        vecs[4] = '{1'b0, 4'b0101, 7, 3'd3, 16'h0007, 3'd0, 1'b1, 4'b0000, 16'h0007, 1'b1};
        repeat (3) @(negedge clk);
        chk("rst_lfsr", 32'(dut.r_lfsr), 32'hACE1);
        reset = 1'b0;
        f_reset = 1'b0;
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'h0);
        chk("rst_stim", 32'(stimLed), 32'd0);
        chk("rst_bestvalid", 32'(bestValid), 32'd0);
        chk("rst_best", 32'(bestBcd), 32'h0);
        chk("rst_winner", 32'(winner), 32'd0);
        chk("rst_foulmask", 32'(foulMask), 32'd0);
        chk("rst_tie", 32'(tie), 32'd0);

        playerBtn = 4'b0010;
        repeat (4) @(negedge clk);
        playerBtn = 4'd0;
        repeat (2) @(negedge clk);
        chk("idle_press_state", 32'(state), 32'd0);
        chk("idle_press_foul", 32'(foulMask), 32'd0);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        enter_wait("midgo");
        wait_stim("midgo");
        repeat (300) @(negedge clk);
        chk("midgo_state", 32'(state), 32'd2);
        chk("midgo_bcd", 32'(bcd), 32'h0030);
        #1 reset = 1'b1;
        #1;
        chk("midgo_rst_state", 32'(state), 32'd0);
        chk("midgo_rst_bcd", 32'(bcd), 32'h0);
        chk("midgo_rst_best", 32'(bestBcd), 32'h0);
        chk("midgo_rst_bestvalid", 32'(bestValid), 32'd0);
        chk("midgo_rst_stim", 32'(stimLed), 32'd0);
        @(negedge clk) reset = 1'b0;

        n = 0;
        @(negedge clk) f_start = 1'b1;
        while (f_state != 3'd1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        f_start = 1'b0;
        chk("to_wait", 32'(f_state), 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 3) f_start = 1'b1;
            if (n == 6) f_start = 1'b0;
            if (n == 100) f_start = 1'b1;
            if (n == 103) f_start = 1'b0;
        end while (f_state != 3'd5 && n < 12000);
        chk("to_cycles", 32'(n), 32'd10004);
        chk("to_state", 32'(f_state), 32'd5);
        chk("to_bcd", 32'(f_bcd), 32'h9999);
        chk("to_bestvalid", 32'(f_bv), 32'd0);
        chk("to_stim", 32'(f_stim), 32'd0);
        repeat (20) @(negedge clk);
        chk("to_hold_bcd", 32'(f_bcd), 32'h9999);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reaction_timer_multi.md
# reaction_timer_multi

Parametrised reaction-timer core for the Nexys4 DDR designs. It supports 1–8 players, a pseudo-random stimulus delay, foul and timeout detection, a millisecond BCD result and a best-time register. It sits between the board-level button debouncers and the seven-segment/LED drivers in the top level: it drives the BCD digits and status flags, and the existing display multiplexer renders them.

## Interface
- CLK_HZ, 100_000_000, input clock frequency.
- TICK_HZ, 1000, counting resolution (one BCD count per tick).
- PLAYERS, 2, number of player buttons (1..8).
- MIN_DELAY, 1000, minimum stimulus delay in ticks.
- RAND_BITS, 12, width of the random delay added to MIN_DELAY (0..2^RAND_BITS-1 ticks).
- TEST_DELAY, 500, fixed stimulus delay in ticks used in test mode.

Ports (clock and reset first):
- clk, in, 1, system clock.
- reset, in, 1, asynchronous, active-high; clears all state.
- startBtn, in, 1, debounced start level, asynchronous to clk.
- testmodeBtn, in, 1, debounced level; sampled at round start.
- playerBtn, in, PLAYERS, debounced player levels, asynchronous to clk.
- stimLed, out, 1, stimulus lamp; high only in GO.
- bcd, out, 16, current/last reaction time as 4 BCD digits, ms.
- bestBcd, out, 16, best valid time since reset.
- bestValid, out, 1, bestBcd holds a real result.
- winner, out, 3, index of the winning player.
- foulMask, out, PLAYERS, players that pressed during WAIT.
- tie, out, 1, more than one player pressed on the winning cycle.
- state, out, 3, FSM state code.

## Operation
- All button inputs pass through a 2-flop synchroniser followed by rising-edge detection. Only edges act; held levels do nothing.
- LFSR: 16-bit Fibonacci, taps 16/14/13/11, seed 16'hACE1 on reset. It advances every clk, never stalls, and never reaches all-zero.
- Prescaler: counts 0..CLK_HZ/TICK_HZ-1 and emits a 1-cycle tick at terminal count. It clears to 0 on every entry to WAIT and to GO, so the first tick occurs exactly DIV cycles after entry.
- FSM codes: IDLE=0, WAIT=1, GO=2, DONE=3, FOUL=4, TIMEOUT=5.
- IDLE, DONE, FOUL or TIMEOUT, on a startBtn edge: go to WAIT.
  - Latch delay = TEST_DELAY if testmodeBtn is high, else MIN_DELAY + LFSR[RAND_BITS-1:0].
  - Clear bcd, foulMask, tie and winner.
- WAIT: decrement the delay on each tick.
  - Any player edge: go to FOUL. foulMask = the set of edges in that cycle. This takes priority over delay expiry in the same cycle.
  - Delay reaches 0: go to GO.
- GO: stimLed=1. bcd increments by one BCD count per tick, with digit-wise carry.
  - Any player edge: go to DONE. winner = lowest-index pressing player. tie = popcount(edges)>1. bcd freezes. A press and a tick in the same cycle freeze the pre-increment value.
  - bcd reaches 9999 with no press: go to TIMEOUT. bcd holds 9999.
- DONE: if !bestValid or bcd < bestBcd, load bestBcd=bcd and set bestValid. The compare is an unsigned compare of the packed 16-bit BCD, which is numerically correct. FOUL and TIMEOUT never update best.
- startBtn edges in WAIT or GO are ignored. testmodeBtn is read only on the start edge.
- Player edges in IDLE, DONE, FOUL or TIMEOUT are ignored.

## Timing
- Reset values: state=IDLE, stimLed=0, bcd=0000, bestBcd=0000, bestValid=0, winner=0, foulMask=0, tie=0, prescaler=0, LFSR=16'hACE1.
- An input level first sampled high at clk edge k is acted on at edge k+2. Outputs reflect the action after edge k+2.
- All outputs are registered and change only on clk edges (or asynchronously on reset).
- WAIT to GO happens on the edge where the delay-th tick occurs. GO lasts at most 9999 ticks.
- bestBcd/bestValid update on the edge after entering DONE.
- Reset mid-round: immediate return to IDLE with all reset values, including loss of best time.

## Test plan
All cases use a bench with CLK_HZ=1000 and TICK_HZ=100 (10 cycles/tick), PLAYERS=4, TEST_DELAY=5.
- Reset held, then released -> state=0, bcd=0000, stimLed=0, bestValid=0, LFSR=ACE1.
- testmodeBtn=1 + start edge -> state=1, stimLed rises 50 cycles after WAIT entry. Player 2 pressed 123 ticks into GO -> state=3, bcd=0123, winner=2, bestBcd=0123, bestValid=1.
- Second round with a press at 200 ticks -> bcd=0200, bestBcd stays 0123. Third round at 45 ticks -> bestBcd=0045.
- Players 1 and 3 pressed during WAIT in the same cycle -> state=4, foulMask=4'b1010, stimLed never rises, best unchanged.
- Players 0 and 2 pressed on the same GO cycle -> winner=0, tie=1.
- No press in GO -> state=5 after 9999 ticks, bcd=9999, bestValid unchanged. Start edges during WAIT and GO are ignored. Reset asserted mid-GO -> IDLE with all reset values.
